seg_scan_driver: RTL and testbench

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

---
 rtl/seg_pkg.sv | 19 +
 rtl/seg_hex_decode.sv | 11 +
 rtl/seg_scan_driver.sv | 124 ++++++++++++
 tb/tb_seg_scan_driver.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared segment constants and the hex-to-segment lookup for the scan driver.
package seg_pkg;

  localparam int unsigned SEG_W = 7;

  // Active-low {a,b,c,d,e,f,g}; every segment off.
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  // Entry n is the pattern for hex digit n (listed F down to 0).
  localparam logic [15:0][SEG_W-1:0] SEG_DIGIT = {
    7'h38, 7'h30, 7'h42, 7'h31, 7'h60, 7'h08, 7'h04, 7'h00,
    7'h0F, 7'h20, 7'h24, 7'h4C, 7'h06, 7'h12, 7'h4F, 7'h01
  };

  function automatic logic [SEG_W-1:0] hex_to_seg(input logic [3:0] nibble);
    return SEG_DIGIT[nibble];
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational nibble-to-cathode decoder (active-low segments).
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0]       nibble,
  output logic [SEG_W-1:0] segments_c
);

  assign segments_c = hex_to_seg(nibble);

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scan driver with anti-ghost blanking, blinking and
// frame-synchronous double-buffered digit updates.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned REFRESH_DIV  = 32768,
  parameter int unsigned BLANK_CYCLES = 64,
  parameter int unsigned BLINK_LOG2   = 25
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digit_value,
  input  logic [NUM_DIGITS-1:0]   digit_enable,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    load,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [SEG_W-1:0]        cathode,
  output logic                    frame_done
);

  localparam int unsigned PW = $clog2(REFRESH_DIV);
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned VW = 4 * NUM_DIGITS;

  generate
    if (NUM_DIGITS < 1 || NUM_DIGITS > 16) begin : g_bad_digits
      $error("seg_scan_driver: NUM_DIGITS must be 1..16");
    end
    if (REFRESH_DIV < 2) begin : g_bad_div
      $error("seg_scan_driver: REFRESH_DIV must be at least 2");
    end
    if (BLANK_CYCLES >= REFRESH_DIV) begin : g_bad_blank
      $error("seg_scan_driver: BLANK_CYCLES must be less than REFRESH_DIV");
    end
    if (BLINK_LOG2 < 1) begin : g_bad_blink
      $error("seg_scan_driver: BLINK_LOG2 must be at least 1");
    end
  endgenerate

  logic [PW-1:0]         presc;
  logic [IW-1:0]         idx;
  logic [BLINK_LOG2-1:0] blink_cnt;

  logic [VW-1:0]         act_value,  pend_value;
  logic [NUM_DIGITS-1:0] act_enable, pend_enable;
  logic [NUM_DIGITS-1:0] act_blink,  pend_blink;
  logic                  pend_valid;

  logic                  slot_end_c;
  logic                  boundary_c;
  logic                  dark_c;
  logic [3:0]            nibble_c;
  logic [SEG_W-1:0]      segments_c;
  logic [NUM_DIGITS-1:0] anode_c;
  logic [SEG_W-1:0]      cathode_c;

  // Select the active digit and decide whether its slot is lit right now.
  always_comb begin
    slot_end_c = (presc == PW'(REFRESH_DIV - 1));
    boundary_c = slot_end_c && (idx == IW'(NUM_DIGITS - 1));
    nibble_c   = act_value[{idx, 2'b00} +: 4];
    dark_c     = (32'(presc) < BLANK_CYCLES) || !act_enable[idx] ||
                 (act_blink[idx] && blink_cnt[BLINK_LOG2-1]);
    anode_c    = dark_c ? '1 : ~(NUM_DIGITS'(1) << idx);
    cathode_c  = dark_c ? SEG_BLANK : segments_c;
  end

  seg_hex_decode u_hex_decode (
    .nibble     (nibble_c),
    .segments_c (segments_c)
  );

  // Scan counters and registered display outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      presc      <= '0;
      idx        <= '0;
      blink_cnt  <= '0;
      anode      <= '1;
      cathode    <= SEG_BLANK;
      frame_done <= 1'b0;
    end else begin
      presc      <= slot_end_c ? '0 : presc + PW'(1);
      if (slot_end_c) begin
        idx <= boundary_c ? '0 : idx + IW'(1);
      end
      blink_cnt  <= blink_cnt + BLINK_LOG2'(1);
      anode      <= anode_c;
      cathode    <= cathode_c;
      frame_done <= boundary_c;
    end
  end

  // Loads land in the shadow copy; active only changes on the frame boundary.
  always_ff @(posedge clock) begin
    if (reset) begin
      act_value   <= '0;
      act_enable  <= '0;
      act_blink   <= '0;
      pend_value  <= '0;
      pend_enable <= '0;
      pend_blink  <= '0;
      pend_valid  <= 1'b0;
    end else if (boundary_c) begin
      if (load) begin
        act_value  <= digit_value;
        act_enable <= digit_enable;
        act_blink  <= blink_mask;
      end else if (pend_valid) begin
        act_value  <= pend_value;
        act_enable <= pend_enable;
        act_blink  <= pend_blink;
      end
      pend_valid <= 1'b0;
    end else if (load) begin
      pend_value  <= digit_value;
      pend_enable <= digit_enable;
      pend_blink  <= blink_mask;
      pend_valid  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: directed table, corner sequences,
// and random traffic checked against a cycle-count based reference model.
module tb_seg_scan_driver;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int BC = 2;
  localparam int BL = 6;
  localparam int FRAME = ND * RD;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [15:0]   digit_value = '0;
  logic [3:0]    digit_enable = '0;
  logic [3:0]    blink_mask = '0;
  logic          load = 1'b0;
  logic [3:0]    anode;
  logic [6:0]    cathode;
  logic          frame_done;

  int total = 0;
  int bad = 0;

  seg_scan_driver #(
    .NUM_DIGITS   (ND),
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC),
    .BLINK_LOG2   (BL)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .digit_value  (digit_value),
    .digit_enable (digit_enable),
    .blink_mask   (blink_mask),
    .load         (load),
    .anode        (anode),
    .cathode      (cathode),
    .frame_done   (frame_done)
  );

  always #5 clock = ~clock;

  logic [6:0] seg_ref [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // Reference model: t counts cycles since reset release.
  int         t = 0;
  logic [3:0] m_val [ND];
  logic       m_en  [ND];
  logic       m_bm  [ND];
  logic [3:0] p_val [ND];
  logic       p_en  [ND];
  logic       p_bm  [ND];
  logic       p_flag = 1'b0;

  task automatic model_out(output logic [3:0] ea, output logic [6:0] ec, output logic ef);
    int slot_pos = t % RD;
    int digit = (t / RD) % ND;
    bit phase = (t % (1 << BL)) >= (1 << (BL - 1));
    bit dark = (slot_pos < BC) || !m_en[digit] || (m_bm[digit] && phase);
    ea = dark ? 4'hF : ~(4'(1) << digit);
    ec = dark ? 7'h7F : seg_ref[m_val[digit]];
    ef = ((t % FRAME) == FRAME - 1);
  endtask

  task automatic model_update();
    if (reset) begin
      t = 0;
      p_flag = 1'b0;
      for (int i = 0; i < ND; i++) begin
        m_val[i] = '0; m_en[i] = 1'b0; m_bm[i] = 1'b0;
        p_val[i] = '0; p_en[i] = 1'b0; p_bm[i] = 1'b0;
      end
    end else begin
      if ((t % FRAME) == FRAME - 1) begin
        for (int i = 0; i < ND; i++) begin
          if (load) begin
            m_val[i] = digit_value[4*i +: 4]; m_en[i] = digit_enable[i]; m_bm[i] = blink_mask[i];
          end else if (p_flag) begin
            m_val[i] = p_val[i]; m_en[i] = p_en[i]; m_bm[i] = p_bm[i];
          end
        end
        p_flag = 1'b0;
      end else if (load) begin
        for (int i = 0; i < ND; i++) begin
          p_val[i] = digit_value[4*i +: 4]; p_en[i] = digit_enable[i]; p_bm[i] = blink_mask[i];
        end
        p_flag = 1'b1;
      end
      t++;
    end
  endtask

  // One clock: predict, advance model, compare every output after the edge.
  task automatic tick();
    logic [3:0] ea;
    logic [6:0] ec;
    logic       ef;
    if (reset) begin
      ea = 4'hF; ec = 7'h7F; ef = 1'b0;
    end else begin
      model_out(ea, ec, ef);
    end
    model_update();
    @(posedge clock);
    #1;
    total++;
    if (anode !== ea || cathode !== ec || frame_done !== ef) begin
      bad++;
      $display("FAIL model t=%0d: anode=%h cathode=%h frame_done=%b expected %h %h %b",
               t, anode, cathode, frame_done, ea, ec, ef);
    end
  endtask

  task automatic check(input string nm, input logic [3:0] ea, input logic [6:0] ec);
    total++;
    if (anode !== ea || cathode !== ec) begin
      bad++;
      $display("FAIL %s t=%0d: anode=%h cathode=%h expected %h %h", nm, t, anode, cathode, ea, ec);
    end
  endtask

  task automatic run_to(input int fc);
    int n = 0;
    while ((t % FRAME) != fc && n < 2 * FRAME) begin
      tick();
      n++;
    end
    total++;
    if ((t % FRAME) != fc) begin
      bad++;
      $display("FAIL run_to: frame cycle=%0d expected %0d", t % FRAME, fc);
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] en, input logic [3:0] bm);
    digit_value = v; digit_enable = en; blink_mask = bm; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  typedef struct {
    int         k;
    logic [3:0] an;
    logic [6:0] cat;
    logic       fd;
  } vec_t;

  vec_t vecs [13];

  initial begin
    // Expected outputs after edge k, load of 4321 issued in cycle 0.
    vecs[0]  = '{1,  4'hF, 7'h7F, 1'b0};
    vecs[1]  = '{10, 4'hF, 7'h7F, 1'b0};
    vecs[2]  = '{32, 4'hF, 7'h7F, 1'b1};
    vecs[3]  = '{33, 4'hF, 7'h7F, 1'b0};
    vecs[4]  = '{34, 4'hF, 7'h7F, 1'b0};
    vecs[5]  = '{35, 4'b1110, 7'b1001111, 1'b0};
    vecs[6]  = '{40, 4'b1110, 7'b1001111, 1'b0};
    vecs[7]  = '{41, 4'hF, 7'h7F, 1'b0};
    vecs[8]  = '{43, 4'b1101, 7'b0010010, 1'b0};
    vecs[9]  = '{51, 4'b1011, 7'b0000110, 1'b0};
    vecs[10] = '{59, 4'b0111, 7'b1001100, 1'b0};
    vecs[11] = '{64, 4'b0111, 7'b1001100, 1'b1};
    vecs[12] = '{67, 4'b1110, 7'b1001111, 1'b0};

    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("reset_state", 4'hF, 7'h7F);

    do_load(16'h4321, 4'hF, 4'h0);
    foreach (vecs[i]) begin
      while (t < vecs[i].k) tick();
      total++;
      if (anode !== vecs[i].an || cathode !== vecs[i].cat || frame_done !== vecs[i].fd) begin
        bad++;
        $display("FAIL table[%0d] k=%0d: anode=%h cathode=%h frame_done=%b expected %h %h %b",
                 i, vecs[i].k, anode, cathode, frame_done, vecs[i].an, vecs[i].cat, vecs[i].fd);
      end
    end

    // Mid-frame load must not tear the current frame.
    run_to(10);
    do_load(16'h8888, 4'hF, 4'h0);
    run_to(19);
    check("no_tear_hold", 4'b1011, 7'b0000110);
    run_to(3);
    check("no_tear_new", 4'b1110, 7'b0000000);

    // Load on the boundary cycle goes straight to active; next load survives.
    run_to(FRAME - 1);
    do_load(16'hFFFF, 4'hF, 4'h0);
    run_to(3);
    check("boundary_load", 4'b1110, 7'b0111000);
    run_to(5);
    do_load(16'h1234, 4'hF, 4'h0);
    run_to(19);
    check("second_load_pending", 4'b1011, 7'b0111000);
    run_to(3);
    check("second_load_applied", 4'b1110, 7'b1001100);

    // Blink on digit 0 only.
    do_load(16'h1234, 4'hF, 4'b0001);
    for (int f = 0; f < 4; f++) begin
      bit ph;
      run_to(3);
      ph = ((t - 1) % (1 << BL)) >= (1 << (BL - 1));
      check("blink_digit0", ph ? 4'hF : 4'b1110, ph ? 7'h7F : 7'b1001100);
      run_to(11);
      check("blink_digit1_steady", 4'b1101, 7'b0000110);
    end

    // Reset mid-frame.
    run_to(17);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midframe_reset", 4'hF, 7'h7F);
    run_to(3);
    check("after_reset_dark", 4'hF, 7'h7F);
    do_load(16'h4321, 4'hF, 4'h0);
    run_to(3);
    check("after_reset_restart", 4'b1110, 7'b1001111);

    // Disabled digits stay dark.
    do_load(16'h4321, 4'b1010, 4'h0);
    run_to(3);
    check("enable_digit0_dark", 4'hF, 7'h7F);
    run_to(11);
    check("enable_digit1_lit", 4'b1101, 7'b0010010);
    run_to(19);
    check("enable_digit2_dark", 4'hF, 7'h7F);
    run_to(27);
    check("enable_digit3_lit", 4'b0111, 7'b1001100);

    // Random traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      digit_value  = 16'($urandom);
      digit_enable = 4'($urandom);
      blink_mask   = 4'($urandom);
      load         = ($urandom_range(0, 11) == 0);
      reset        = ($urandom_range(0, 399) == 0);
      tick();
    end
    load = 1'b0;
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
